// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB consumer. Selects the writeback value, commits it to a
// 2**ADDR_W-entry register file with two combinational read ports, and counts
// committed writebacks. Define WB_REGFILE_BYPASS_EN for same-cycle
// write-to-read bypass on both read ports.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite_WB,
   input  logic              MemToReg_WB,
   input  logic [DATA_W-1:0] execution_out_WB,
   input  logic [DATA_W-1:0] ReadData_WB,
   input  logic [ADDR_W-1:0] WriteReg_WB,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] WriteData_WB,
   output logic [CNT_W-1:0]  wb_count
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regFile [DEPTH];
   logic              commit;
   logic              bypass1;
   logic              bypass2;

   assign WriteData_WB = MemToReg_WB ? ReadData_WB : execution_out_WB;
   assign commit       = RegWrite_WB && (WriteReg_WB != '0);

`ifdef WB_REGFILE_BYPASS_EN
   assign bypass1 = commit && !reset && (ReadReg1 == WriteReg_WB);
   assign bypass2 = commit && !reset && (ReadReg2 == WriteReg_WB);
`else
   assign bypass1 = 1'b0;
   assign bypass2 = 1'b0;
`endif

   // Index 0 reads as zero regardless of array contents or bypass.
   assign ReadData1 = (ReadReg1 == '0) ? '0 : bypass1 ? WriteData_WB : regFile[ReadReg1];
   assign ReadData2 = (ReadReg2 == '0) ? '0 : bypass2 ? WriteData_WB : regFile[ReadReg2];

   // Register array: async clear, one-edge write of the selected value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regFile[i] <= '0;
      end else if (commit) begin
         regFile[WriteReg_WB] <= WriteData_WB;
      end
   end

   // Committed-writeback counter, wraps naturally at 2**CNT_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wb_count <= '0;
      else if (commit) wb_count <= wb_count + 1'b1;
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized self-checking bench for wb_regfile against an
// array/counter reference model; a second instance with CNT_W=4 exercises
// counter wrap. Expectations follow WB_REGFILE_BYPASS_EN when defined.
module tb_wb_regfile;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        RegWrite_WB = 1'b0;
   logic        MemToReg_WB = 1'b0;
   logic [31:0] execution_out_WB = '0;
   logic [31:0] ReadData_WB = '0;
   logic [4:0]  WriteReg_WB = '0;
   logic [4:0]  ReadReg1 = '0;
   logic [4:0]  ReadReg2 = '0;
   logic [31:0] ReadData1, ReadData2, WriteData_WB, wb_count;
   logic [31:0] smallRd1, smallRd2, smallWd;
   logic [3:0]  smallCount;

   logic [31:0] model [32];
   logic [31:0] modelCount;
   int          modelSmall;
   int          checks = 0;
   int          errors = 0;
   bit          bypassOn;

   wb_regfile dut (
      .clk(clk), .reset(reset), .RegWrite_WB(RegWrite_WB), .MemToReg_WB(MemToReg_WB),
      .execution_out_WB(execution_out_WB), .ReadData_WB(ReadData_WB), .WriteReg_WB(WriteReg_WB),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
      .WriteData_WB(WriteData_WB), .wb_count(wb_count)
   );

   wb_regfile #(.CNT_W(4)) dutSmall (
      .clk(clk), .reset(reset), .RegWrite_WB(RegWrite_WB), .MemToReg_WB(MemToReg_WB),
      .execution_out_WB(execution_out_WB), .ReadData_WB(ReadData_WB), .WriteReg_WB(WriteReg_WB),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(smallRd1), .ReadData2(smallRd2),
      .WriteData_WB(smallWd), .wb_count(smallCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] r);
      logic [31:0] wd;
      wd = MemToReg_WB ? ReadData_WB : execution_out_WB;
      if (r == 0 || reset) return 32'h0;
      if (bypassOn && RegWrite_WB && WriteReg_WB == r) return wd;
      return model[r];
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 32; i++) model[i] = '0;
      modelCount = '0;
      modelSmall = 0;
   endtask

   task automatic step(input logic rw, input logic mtr, input logic [31:0] eo, input logic [31:0] rd,
                       input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
      @(negedge clk);
      RegWrite_WB = rw; MemToReg_WB = mtr; execution_out_WB = eo; ReadData_WB = rd;
      WriteReg_WB = wr; ReadReg1 = r1; ReadReg2 = r2;
      #1;
      check("wdata", WriteData_WB, mtr ? rd : eo);
      check("rd1", ReadData1, expRead(r1));
      check("rd2", ReadData2, expRead(r2));
      @(posedge clk);
      #1;
      if (rw && wr != 0) begin
         model[wr] = mtr ? rd : eo;
         modelCount = modelCount + 1;
         modelSmall = (modelSmall + 1) % 16;
      end
      check("count", wb_count, modelCount);
      check("count4", smallCount, modelSmall);
   endtask

   initial begin
`ifdef WB_REGFILE_BYPASS_EN
      bypassOn = 1'b1;
`else
      bypassOn = 1'b0;
`endif
      clearModel();
      repeat (2) @(posedge clk);
      #1;
      ReadReg1 = 5'd3;
      #1;
      check("rst_rd1", ReadData1, 32'h0);
      check("rst_count", wb_count, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      step(1, 0, 32'h0000_1234, 32'h0, 5'd8, 5'd8, 5'd0);
      step(0, 0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);
      step(1, 1, 32'h1111_1111, 32'hDEAD_BEEF, 5'd9, 5'd9, 5'd8);
      step(1, 1, 32'h1111_1111, 32'hDEAD_BEEF, 5'd0, 5'd9, 5'd0);
      step(0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
      check("load9", ReadData1, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++)
         step(0, i[0], $urandom, $urandom, 5'd8, 5'd8, 5'd0);
      check("keep8", ReadData1, 32'h0000_1234);
      step(1, 0, 32'h0000_5678, 32'h0, 5'd8, 5'd8, 5'd8);
      step(0, 0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
      check("new8", ReadData1, 32'h0000_5678);

      step(1, 0, 32'hA5A5_0005, 32'h0, 5'd5, 5'd0, 5'd0);
      step(1, 1, 32'h0, 32'h3131_3131, 5'd31, 5'd0, 5'd0);
      @(negedge clk);
      RegWrite_WB = 0; ReadReg1 = 5'd5; ReadReg2 = 5'd31;
      #1;
      check("pre_rst5", ReadData1, 32'hA5A5_0005);
      check("pre_rst31", ReadData2, 32'h3131_3131);
      #1;
      reset = 1'b1;
      #1;
      clearModel();
      check("async_rd1", ReadData1, 32'h0);
      check("async_rd2", ReadData2, 32'h0);
      check("async_count", wb_count, 32'h0);
      check("async_count4", smallCount, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      step(1, 0, 32'h0000_7777, 32'h0, 5'd5, 5'd0, 5'd0);
      @(negedge clk);
      RegWrite_WB = 1; MemToReg_WB = 0; execution_out_WB = 32'h0000_AAAA; WriteReg_WB = 5'd5; ReadReg1 = 5'd5;
      #2;
      reset = 1'b1;
      #1;
      clearModel();
      check("rst_bypass", ReadData1, 32'h0);
      @(posedge clk);
      #1;
      check("rst_edge_count", wb_count, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      RegWrite_WB = 0;
      #1;
      check("rst_edge_rd", ReadData1, 32'h0);

      for (int i = 0; i < 17; i++)
         step(1, 0, 32'h100 + i, 32'h0, 5'(1 + i % 31), 5'd1, 5'd2);
      check("wrap_end", smallCount, 32'd1);

      for (int i = 0; i < 300; i++) begin
         logic [4:0] wr, r1, r2;
         wr = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         step(1'($urandom), 1'($urandom), $urandom, $urandom, wr, r1, r2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
